bus_memory: RTL and testbench

Memory-side responder for the 8-bit CPU's memory bus: 256-byte address space with combinational read and clocked write, matching the CPU's single-cycle fetch and load/save timing. Adds a boot loader that streams a program into RAM while holding the CPU in reset. Adds a memory-mapped I/O window with a byte input register and an output FIFO. Sits between the CPU and the top-level pins/testbench.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 50 +++++
 rtl/bus_memory.sv | 156 +++++++++++++++
 tb/tb_bus_memory.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory bus: I/O window addresses,
// STATUS register bit positions and the boot sequencer states.
package cpu_pkg;

  localparam logic [7:0] IO_BASE     = 8'hFC;
  localparam logic [7:0] ADDR_IN     = 8'hFD;
  localparam logic [7:0] ADDR_STATUS = 8'hFE;
  localparam logic [7:0] ADDR_OUT    = 8'hFF;

  localparam int ST_IN_FULL   = 0;
  localparam int ST_OUT_FULL  = 1;
  localparam int ST_OUT_EMPTY = 2;
  localparam int ST_OUT_OVF   = 3;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } boot_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO for the OUT_DATA port. Pointers carry an extra wrap
// bit so full and empty are distinguished without a separate count.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = pop && !empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign w_do_push = push && (!full || w_do_pop);

  assign dout = empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bus_memory.sv
// Memory-side responder for the 8-bit CPU: 252-byte RAM, boot loader that
// holds the CPU in reset while streaming a program, and a small I/O window.
module bus_memory
  import cpu_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_address,
  input  logic       mem_wen,
  input  logic [7:0] mem_data_in,
  output logic [7:0] mem_data_out,
  output logic       cpu_rst,
  input  logic       boot,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       load_overflow,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready
);

  boot_state_t r_state, w_state_next;
  logic [7:0]  r_ptr, w_ptr_next;
  logic        r_load_overflow, w_load_overflow_next;
  logic        r_in_full;
  logic [7:0]  r_in_data;
  logic        r_out_overflow;
  logic [7:0]  r_ram [256];

  logic        w_boot_run;
  logic        w_cpu_we;
  logic        w_load_store;
  logic        w_ram_we;
  logic [7:0]  w_ram_addr;
  logic [7:0]  w_ram_wdata;
  logic        w_fifo_push;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_dout;
  logic [7:0]  w_status;

  always_comb begin
    w_state_next         = r_state;
    w_ptr_next           = r_ptr;
    w_load_overflow_next = r_load_overflow;
    cpu_rst              = 1'b1;
    load_ready           = 1'b0;
    case (r_state)
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (r_ptr < IO_BASE) w_ptr_next = r_ptr + 8'd1;
          else                 w_load_overflow_next = 1'b1;
          if (load_last) w_state_next = RUN;
        end
      end
      RUN: begin
        cpu_rst = 1'b0;
        if (boot) begin
          w_state_next         = LOAD;
          w_ptr_next           = 8'h00;
          w_load_overflow_next = 1'b0;
        end
      end
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= LOAD;
      r_ptr           <= 8'h00;
      r_load_overflow <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_ptr           <= w_ptr_next;
      r_load_overflow <= w_load_overflow_next;
    end
  end

  // CPU writes only count in RUN, and a boot pulse suppresses them.
  assign w_boot_run   = (r_state == RUN) && boot;
  assign w_cpu_we     = (r_state == RUN) && mem_wen && !boot;
  assign w_load_store = (r_state == LOAD) && load_valid && (r_ptr < IO_BASE);
  assign w_ram_we     = w_load_store || (w_cpu_we && (mem_address < IO_BASE));
  assign w_ram_addr   = w_load_store ? r_ptr : mem_address;
  assign w_ram_wdata  = w_load_store ? load_data : mem_data_in;

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_addr] <= w_ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || w_boot_run) begin
      r_in_full <= 1'b0;
      if (rst) r_in_data <= 8'h00;
    end else if (in_valid && !r_in_full) begin
      r_in_full <= 1'b1;
      r_in_data <= in_data;
    end else if (w_cpu_we && (mem_address == ADDR_IN)) begin
      r_in_full <= 1'b0;
    end
  end

  assign w_fifo_push = w_cpu_we && (mem_address == ADDR_OUT);

  byte_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fifo_push),
    .pop   (out_ready),
    .flush (w_boot_run),
    .din   (mem_data_in),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_overflow <= 1'b0;
    end else if (w_fifo_push && w_fifo_full && !out_ready) begin
      r_out_overflow <= 1'b1;
    end else if (w_cpu_we && (mem_address == ADDR_STATUS) && mem_data_in[ST_OUT_OVF]) begin
      r_out_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_status               = 8'h00;
    w_status[ST_IN_FULL]   = r_in_full;
    w_status[ST_OUT_FULL]  = w_fifo_full;
    w_status[ST_OUT_EMPTY] = w_fifo_empty;
    w_status[ST_OUT_OVF]   = r_out_overflow;
  end

  always_comb begin
    mem_data_out = 8'h00;
    if (mem_address < IO_BASE)            mem_data_out = r_ram[mem_address];
    else if (mem_address == ADDR_IN)      mem_data_out = r_in_data;
    else if (mem_address == ADDR_STATUS)  mem_data_out = w_status;
  end

  assign load_overflow = r_load_overflow;
  assign in_ready      = !r_in_full;
  assign out_valid     = !w_fifo_empty;
  assign out_data      = w_fifo_dout;

endmodule

// File: tb/tb_bus_memory.sv
// Self-checking bench for bus_memory: loader, RAM, I/O window and boot,
// with expected read/FIFO bytes queued at stimulus time and popped at output.
module tb_bus_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_address;
  logic       mem_wen;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic       cpu_rst;
  logic       boot;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       load_overflow;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rd_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] model_ram [256];

  always #5 clk = ~clk;

  bus_memory #(.OUT_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_wen(mem_wen),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .cpu_rst(cpu_rst), .boot(boot),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_overflow(load_overflow),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end else begin
      $display("ok   %s = %02h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    rd_q.push_back(exp);
    mem_address = addr;
    @(negedge clk);
    check(tag, mem_data_out, rd_q.pop_front());
    tick();
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
    mem_address = addr;
    mem_data_in = data;
    mem_wen     = 1'b1;
    tick();
    mem_wen     = 1'b0;
  endtask

  task automatic fifo_write(input logic [7:0] data);
    if (fifo_q.size() < 4) fifo_q.push_back(data);
    cpu_write(8'hFF, data);
  endtask

  task automatic drain(input string tag, input int exp_count);
    int popped = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (!out_valid) break;
      if (fifo_q.size() == 0) fifo_q.push_back(8'hXX);
      check(tag, out_data, fifo_q.pop_front());
      popped++;
      tick();
    end
    check({tag, "_count"}, 8'(popped), 8'(exp_count));
    check({tag, "_valid_low"}, {7'd0, out_valid}, 8'h00);
    out_ready = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_address = 8'h00; mem_wen = 1'b0; mem_data_in = 8'h00;
    boot = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_cpu_rst", {7'd0, cpu_rst}, 8'h01);
    check("rst_load_ready", {7'd0, load_ready}, 8'h01);
    check("rst_load_ovf", {7'd0, load_overflow}, 8'h00);
    check("rst_in_ready", {7'd0, in_ready}, 8'h01);
    check("rst_out_valid", {7'd0, out_valid}, 8'h00);
    check("rst_out_data", out_data, 8'h00);
    expect_read("rst_status", 8'hFE, 8'h04);

    // Three-byte load
    load_valid = 1'b1; load_data = 8'h11; load_last = 1'b0; tick();
    load_data = 8'h22; tick();
    load_data = 8'h33; load_last = 1'b1;
    check("load3_cpu_rst_before", {7'd0, cpu_rst}, 8'h01);
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    check("load3_cpu_rst_after", {7'd0, cpu_rst}, 8'h00);
    check("load3_ready_low", {7'd0, load_ready}, 8'h00);
    check("load3_ovf", {7'd0, load_overflow}, 8'h00);
    expect_read("load3_ram0", 8'h00, 8'h11);
    expect_read("load3_ram1", 8'h01, 8'h22);
    expect_read("load3_ram2", 8'h02, 8'h33);

    // Re-boot and overfill the loader
    boot = 1'b1; tick(); boot = 1'b0;
    check("boot_cpu_rst", {7'd0, cpu_rst}, 8'h01);
    for (int i = 0; i < 253; i++) begin
      logic [7:0] d;
      d = 8'(i * 7 + 3);
      if (i < 252) model_ram[i] = d;
      load_valid = 1'b1; load_data = d; tick();
    end
    load_valid = 1'b0;
    check("ovf_set", {7'd0, load_overflow}, 8'h01);
    check("ovf_still_load", {7'd0, cpu_rst}, 8'h01);
    load_byte(8'hFF, 1'b1);
    check("ovf_run", {7'd0, cpu_rst}, 8'h00);
    check("ovf_sticky", {7'd0, load_overflow}, 8'h01);
    expect_read("big_ram0", 8'h00, model_ram[0]);
    expect_read("big_ram10", 8'h10, model_ram[16]);
    expect_read("big_ram251", 8'hFB, model_ram[251]);

    // CPU RAM and reserved address
    cpu_write(8'h40, 8'h5A); model_ram[8'h40] = 8'h5A;
    expect_read("cpu_ram40", 8'h40, 8'h5A);
    cpu_write(8'hFC, 8'h99);
    expect_read("reserved_fc", 8'hFC, 8'h00);
    expect_read("read_ff", 8'hFF, 8'h00);

    // Input register
    in_valid = 1'b1; in_data = 8'h7E; tick(); in_valid = 1'b0;
    check("in_ready_low", {7'd0, in_ready}, 8'h00);
    expect_read("in_data", 8'hFD, 8'h7E);
    expect_read("in_status", 8'hFE, 8'h05);
    cpu_write(8'hFD, 8'h00);
    check("in_ready_high", {7'd0, in_ready}, 8'h01);
    expect_read("in_status_clr", 8'hFE, 8'h04);

    // Output FIFO overflow and drain
    for (int i = 1; i <= 5; i++) fifo_write(8'(i));
    check("fifo_valid", {7'd0, out_valid}, 8'h01);
    expect_read("fifo_status_ovf", 8'hFE, 8'h0A);
    drain("fifo_drain", 4);
    expect_read("fifo_status_sticky", 8'hFE, 8'h0C);
    cpu_write(8'hFE, 8'h08);
    expect_read("fifo_status_clr", 8'hFE, 8'h04);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) fifo_write(8'(8'h21 + i));
    expect_read("full_status", 8'hFE, 8'h02);
    out_ready = 1'b1;
    mem_address = 8'hFF; mem_data_in = 8'h25; mem_wen = 1'b1;
    @(negedge clk);
    check("pushpop_head", out_data, fifo_q.pop_front());
    fifo_q.push_back(8'h25);
    tick();
    mem_wen = 1'b0;
    drain("pushpop_drain", 4);
    expect_read("pushpop_status", 8'hFE, 8'h04);

    // Boot coincident with a CPU write
    fifo_write(8'h77);
    in_valid = 1'b1; in_data = 8'h3C; tick(); in_valid = 1'b0;
    check("preboot_in_full", {7'd0, in_ready}, 8'h00);
    boot = 1'b1; mem_address = 8'h10; mem_data_in = 8'hEE; mem_wen = 1'b1;
    tick();
    boot = 1'b0; mem_wen = 1'b0;
    fifo_q.delete();
    check("boot_cpu_rst2", {7'd0, cpu_rst}, 8'h01);
    check("boot_fifo_empty", {7'd0, out_valid}, 8'h00);
    check("boot_out_data", out_data, 8'h00);
    check("boot_in_ready", {7'd0, in_ready}, 8'h01);
    check("boot_ovf_clr", {7'd0, load_overflow}, 8'h00);
    expect_read("boot_ram10", 8'h10, model_ram[16]);
    load_byte(8'hC3, 1'b1);
    model_ram[0] = 8'hC3;
    check("boot_run", {7'd0, cpu_rst}, 8'h00);
    expect_read("boot_ptr0", 8'h00, 8'hC3);
    expect_read("boot_ram1", 8'h01, model_ram[1]);

    // Reset mid-run keeps RAM
    rst = 1'b1; tick(); rst = 1'b0;
    check("rerst_cpu_rst", {7'd0, cpu_rst}, 8'h01);
    check("rerst_load_ready", {7'd0, load_ready}, 8'h01);
    expect_read("rerst_ram0", 8'h00, 8'hC3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
